// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz raster timing constants and the vertical-region encoding
// used by the sync generator.
package vga_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SW    = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SW    = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;

    typedef enum logic [1:0] {
        VIS  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } vregion_e;

endpackage

// File: rtl/vga_sync_delay.sv
// sync_delay: DEPTH-stage 1-bit shift register that resets to the inactive-high
// sync level; DEPTH=0 passes the input straight through.
module sync_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_shift
            logic [DEPTH-1:0] sr_q;
            logic [DEPTH-1:0] sr_d;

            always_comb begin
                sr_d    = sr_q << 1;
                sr_d[0] = d;
            end

            always_ff @(posedge clk) begin
                if (rst) sr_q <= '1;
                else     sr_q <= sr_d;
            end

            assign q = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters, visible flag, pipeline-delayed syncs and frame tick.
// Optional GAME_TICK_EN adds game_tick, one pulse per GAME_DIV frame ticks.
module vga_sync_gen #(
    parameter int H_VIS    = vga_pkg::H_VIS,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SW     = vga_pkg::H_SW,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_VIS    = vga_pkg::V_VIS,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SW     = vga_pkg::V_SW,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int SYNC_DLY = 3,
    parameter int GAME_DIV = 2
) (
    input  logic       clk_25m,
    input  logic       rst,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
`ifdef GAME_TICK_EN
    ,
    output logic       game_tick
`endif
);
    import vga_pkg::*;

    localparam logic [9:0] H_LAST    = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] H_VIS_W   = 10'(H_VIS);
    localparam logic [9:0] HS_FIRST  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_VIS + H_FP + H_SW - 1);
    localparam logic [9:0] V_LAST    = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [9:0] V_VIS_W   = 10'(V_VIS);
    localparam logic [9:0] VS_FIRST  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VBP_FIRST = 10'(V_VIS + V_FP + V_SW);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    vregion_e   vreg_q, vreg_d;
    logic       valid_q, valid_d;
    logic       frame_tick_q, frame_tick_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       hsync_raw, vsync_raw;

    // valid and the tick are decoded from next-state counters so they line up with hc/vc
    always_comb begin
        hc_d   = hc_q + 10'd1;
        vc_d   = vc_q;
        vreg_d = vreg_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
            case (vreg_q)
                VIS:  if (vc_d == V_VIS_W)   vreg_d = FP;
                FP:   if (vc_d == VS_FIRST)  vreg_d = SYNC;
                SYNC: if (vc_d == VBP_FIRST) vreg_d = BP;
                BP:   if (vc_d == 10'd0)     vreg_d = VIS;
            endcase
        end
        valid_d      = (hc_d < H_VIS_W) && (vreg_d == VIS);
        frame_tick_d = (vreg_q == VIS) && (vreg_d == FP);
        frame_cnt_d  = frame_cnt_q + 8'(frame_tick_d);
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            hc_q         <= '0;
            vc_q         <= '0;
            vreg_q       <= VIS;
            valid_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            hc_q         <= hc_d;
            vc_q         <= vc_d;
            vreg_q       <= vreg_d;
            valid_q      <= valid_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign hsync_raw = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
    assign vsync_raw = (vreg_q != SYNC);

    sync_delay #(.DEPTH(SYNC_DLY)) u_hsync_dly (
        .clk (clk_25m),
        .rst (rst),
        .d   (hsync_raw),
        .q   (hsync)
    );

    sync_delay #(.DEPTH(SYNC_DLY)) u_vsync_dly (
        .clk (clk_25m),
        .rst (rst),
        .d   (vsync_raw),
        .q   (vsync)
    );

    assign hc         = hc_q;
    assign vc         = vc_q;
    assign valid      = valid_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;

`ifdef GAME_TICK_EN
    localparam logic [7:0] DIV_LAST = 8'(GAME_DIV - 1);

    logic [7:0] div_q, div_d;
    logic       game_tick_q, game_tick_d;

    always_comb begin
        div_d       = div_q;
        game_tick_d = 1'b0;
        if (frame_tick_d) begin
            if (div_q == DIV_LAST) begin
                div_d       = '0;
                game_tick_d = 1'b1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            div_q       <= '0;
            game_tick_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            game_tick_q <= game_tick_d;
        end
    end

    assign game_tick = game_tick_q;
`else
    // game logic runs off frame_tick directly, so the divisor has no effect here
    localparam int unused_game_div = GAME_DIV;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: one full-size instance plus two shrunken-timing
// instances (so many frames fit), checked against an arithmetic raster model.
module tb_vga_sync_gen;

    typedef struct {
        logic [9:0] hc;
        logic [9:0] vc;
        logic       valid;
        logic       hs;
        logic       vs;
        logic       ft;
        logic [7:0] fc;
        logic       gt;
    } exp_t;

    logic clk_25m = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_25m = ~clk_25m;

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    bit started  = 1'b0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic [9:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
    logic       valid_a, hs_a, vs_a, ft_a, gt_a;
    logic       valid_b, hs_b, vs_b, ft_b, gt_b;
    logic       valid_c, hs_c, vs_c, ft_c, gt_c;
    logic [7:0] fc_a, fc_b, fc_c;

    // full 640x480 timing
    vga_sync_gen #(.SYNC_DLY(3), .GAME_DIV(2)) dut_a (
        .clk_25m(clk_25m), .rst(rst), .hc(hc_a), .vc(vc_a), .valid(valid_a),
        .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a), .frame_cnt(fc_a)
`ifdef GAME_TICK_EN
        , .game_tick(gt_a)
`endif
    );

    // shrunken raster: 25 clocks per line, 13 lines per frame
    vga_sync_gen #(.H_VIS(16), .H_FP(2), .H_SW(4), .H_BP(3), .V_VIS(6), .V_FP(2), .V_SW(2), .V_BP(3),
                   .SYNC_DLY(3), .GAME_DIV(2)) dut_b (
        .clk_25m(clk_25m), .rst(rst), .hc(hc_b), .vc(vc_b), .valid(valid_b),
        .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b), .frame_cnt(fc_b)
`ifdef GAME_TICK_EN
        , .game_tick(gt_b)
`endif
    );

    vga_sync_gen #(.H_VIS(16), .H_FP(2), .H_SW(4), .H_BP(3), .V_VIS(6), .V_FP(2), .V_SW(2), .V_BP(3),
                   .SYNC_DLY(0), .GAME_DIV(1)) dut_c (
        .clk_25m(clk_25m), .rst(rst), .hc(hc_c), .vc(vc_c), .valid(valid_c),
        .hsync(hs_c), .vsync(vs_c), .frame_tick(ft_c), .frame_cnt(fc_c)
`ifdef GAME_TICK_EN
        , .game_tick(gt_c)
`endif
    );

`ifndef GAME_TICK_EN
    assign gt_a = 1'b0;
    assign gt_b = 1'b0;
    assign gt_c = 1'b0;
`endif

    // Expected outputs t clocks after the last reset edge, from the raster rules alone
    function automatic exp_t model(input int tt, input int hv, input int hf, input int hs, input int hb,
                                   input int vv, input int vf, input int vs, input int vb,
                                   input int dly, input int div);
        exp_t e;
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        int ft = ht * vt;
        int h  = tt % ht;
        int v  = (tt / ht) % vt;
        int n;
        e.hc    = 10'(h);
        e.vc    = 10'(v);
        e.valid = (tt > 0) && (h < hv) && (v < vv);
        if (tt >= dly) begin
            int hd = (tt - dly) % ht;
            int vd = ((tt - dly) / ht) % vt;
            e.hs = !((hd >= hv + hf) && (hd < hv + hf + hs));
            e.vs = !((vd >= vv + vf) && (vd < vv + vf + vs));
        end else begin
            e.hs = 1'b1;
            e.vs = 1'b1;
        end
        n    = (tt >= vv * ht) ? (tt - vv * ht) / ft + 1 : 0;
        e.ft = (tt >= vv * ht) && ((tt - vv * ht) % ft == 0);
        e.fc = 8'(n % 256);
        e.gt = e.ft && (n % div == 0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    task automatic compareInst(input string tag, input exp_t e, input exp_t a);
        checkOutput({tag, ".hc"},         32'(a.hc),    32'(e.hc));
        checkOutput({tag, ".vc"},         32'(a.vc),    32'(e.vc));
        checkOutput({tag, ".valid"},      32'(a.valid), 32'(e.valid));
        checkOutput({tag, ".hsync"},      32'(a.hs),    32'(e.hs));
        checkOutput({tag, ".vsync"},      32'(a.vs),    32'(e.vs));
        checkOutput({tag, ".frame_tick"}, 32'(a.ft),    32'(e.ft));
        checkOutput({tag, ".frame_cnt"},  32'(a.fc),    32'(e.fc));
`ifdef GAME_TICK_EN
        checkOutput({tag, ".game_tick"},  32'(a.gt),    32'(e.gt));
`endif
    endtask

    task automatic applyStimulus(input logic r, input int n);
        @(negedge clk_25m);
        rst = r;
        repeat (n) @(posedge clk_25m);
    endtask

    // Expectation producer: follows the reset/run schedule and queues one record per edge
    always @(posedge clk_25m) begin
        if (rst) t = 0;
        else     t = t + 1;
        started = 1'b1;
        qa.push_back(model(t, 640, 16, 96, 48, 480, 10, 2, 33, 3, 2));
        qb.push_back(model(t, 16, 2, 4, 3, 6, 2, 2, 3, 3, 2));
        qc.push_back(model(t, 16, 2, 4, 3, 6, 2, 2, 3, 0, 1));
    end

    // Monitor: samples just after each edge and scores against the queued expectation
    always @(posedge clk_25m) begin
        exp_t aa, ab, ac;
        #1;
        if (started) begin
            aa = '{hc_a, vc_a, valid_a, hs_a, vs_a, ft_a, fc_a, gt_a};
            ab = '{hc_b, vc_b, valid_b, hs_b, vs_b, ft_b, fc_b, gt_b};
            ac = '{hc_c, vc_c, valid_c, hs_c, vs_c, ft_c, fc_c, gt_c};
            if (qa.size() == 0 || qb.size() == 0 || qc.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_empty t=%0d actual=0 required=1", t);
            end else begin
                compareInst("a", qa.pop_front(), aa);
                compareInst("b", qb.pop_front(), ab);
                compareInst("c", qc.pop_front(), ac);
            end
        end
    end

    initial begin
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 2000);
        // reset landing inside the small raster's vsync and hsync
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 8 * 25 + 19);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 5);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, int'($urandom_range(20, 900)));
            applyStimulus(1'b1, int'($urandom_range(1, 2)));
        end
        // uninterrupted run past 257 small frames to see frame_cnt wrap
        applyStimulus(1'b0, 6 * 25 + 256 * 325 + 400);
        @(negedge clk_25m);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing source for the pixel compositor: generates the 640x480@60 Hz raster counters hc/vc and the visible-area `valid` flag consumed by the RGB stage.
- Generates hsync/vsync delayed to match the compositor's pixel pipeline latency, so sync edges stay aligned with the registered RGB.
- Issues a one-cycle frame_tick at the start of vertical blanking; game logic (player, enemy, bullet positions) updates on it.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SW, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SW, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_DLY, 3, clocks of delay on hsync/vsync (ROM read + two register stages downstream); legal range 0..7
- GAME_DIV, 2, frames per game_tick (optional feature only); legal range 1..255

Ports:
- clk_25m  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- hc  out  10  horizontal counter, 0..799
- vc  out  10  vertical counter, 0..524
- valid  out  1  1 when hc<640 && vc<480; aligned with hc/vc
- hsync  out  1  active-low horizontal sync, delayed SYNC_DLY clocks
- vsync  out  1  active-low vertical sync, delayed SYNC_DLY clocks
- frame_tick  out  1  one-clock pulse per frame
- frame_cnt  out  8  frame counter, wraps 255->0
- game_tick  out  1  present only with GAME_TICK_EN

Behaviour:
- Clock and reset: clock clk_25m; reset rst, synchronous, active-high.
- Reset values: hc=0, vc=0, valid=0 (registered), hsync=1, vsync=1, every delay-line stage=1, frame_tick=0, frame_cnt=0, game_tick=0.
- hc: increments every clock; at H_TOTAL-1 (799) it wraps to 0.
- vc: increments only on the hc wrap; at V_TOTAL-1 (524) it wraps to 0 on that same hc wrap.
- valid: registered and computed from the next-state counters, so it is exactly coincident with the hc/vc it describes. Zero latency relative to hc/vc.
- Raw sync before delay:
  - hsync_raw=0 for hc in [656,751].
  - vsync_raw=0 for vc in [490,491], for all hc on those lines.
- Delay line: hsync/vsync pass through a SYNC_DLY-deep shift register, so hsync falls SYNC_DLY clocks after hc reaches 656. SYNC_DLY=0 means raw sync is output directly.
- frame_tick: 1 for exactly the cycle where hc==0 && vc==480; 0 otherwise.
- frame_cnt: increments by 1 on that same cycle (mod 256).
- Reset mid-frame: all state returns to reset values on the next edge. The first post-reset cycle shows hc=0, vc=0. The delay line flushes with inactive-high syncs, so there is no spurious sync pulse.
- Simultaneous wrap (hc=799, vc=524): next state hc=0, vc=0, valid=1.
- Raster FSM (vertical region, used for vsync and tick decode): VIS(vc<480) -> FP(480..489) -> SYNC(490..491) -> BP(492..524) -> VIS. Transitions occur only on hc wrap.

Optional Feature:
- Macro: GAME_TICK_EN.
- Defined:
  - game_tick pulses coincident with every GAME_DIV-th frame_tick, counted from reset.
  - The first game_tick occurs at frame_tick #GAME_DIV.
  - A divider counter is added; it resets to 0.
- Undefined: the game_tick port and divider are absent. Game logic uses frame_tick directly.

Decomposition:
- Shared package vga_pkg:
  - the timing constants (H_VIS..V_BP, H_TOTAL=800, V_TOTAL=525);
  - the vertical-region enum {VIS, FP, SYNC, BP}.
- One natural sub-module, sync_delay: a parameterised 1-bit shift register with synchronous reset-to-1, instantiated twice (hsync, vsync).

Test Plan:
- Reset then run 420000 clocks:
  - hc sequence 0..799 repeats;
  - vc increments once per 800 clocks;
  - first frame_tick after exactly 480*800=384000 clocks;
  - frame period 420000 clocks.
- Sync alignment, SYNC_DLY=3: hsync falls 3 clocks after hc==656 and rises 3 clocks after hc==752 (96 low clocks). vsync is low for 1600 clocks starting 3 clocks after (vc=490, hc=0).
- valid check: valid=1 at (hc=0, vc=0) and (639, 479); valid=0 at (640, 0), (0, 480) and (799, 524). Total valid cycles per frame = 307200.
- Assert rst at hc=700, vc=491, mid-vsync:
  - the next cycle shows hc=0, vc=0, hsync=1, vsync=1;
  - no sync low for 3 clocks;
  - frame_cnt=0.
- Run 257 frames: frame_cnt goes 255->0 on frame 256 and reads 1 after frame 257. frame_tick is width 1 each time.
- With GAME_TICK_EN, GAME_DIV=2: game_tick on frame_ticks #2, #4, #6 only. With GAME_DIV=1, game_tick is identical to frame_tick.
